// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer.
//   - default bus / select widths
//   - sequencer state encoding
//   - REG_ZERO: the hardwired-zero register index (reads give 0, writes dropped)
//   - eff_num_src(): folds the reserved source count 3 onto 2
package regfile_sequencer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 4;
  localparam int REG_ZERO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic [1:0] eff_num_src(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// Register-file control sequencer.
// Accepts one request (up to two source reads, one ALU execute, optional
// write-back) and steps the register file through it one phase per cycle.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start / ready                  request handshake (ready only in IDLE)
//   ra_sel, rb_sel, rd_sel         source A, source B, destination register
//   num_src, wb_en                 source count (0..2, 3 = 2), write-back enable
//   register_select                register index presented to the register file
//   reg_file_out / reg_file_in     register-file read-to-bus / write-from-bus strobes
//   bus_in                         shared bus as seen here
//   bus_out, bus_out_en            result toward the bus and its tristate enable
//   op_a, op_b                     captured operands for the ALU
//   exec_req / result_valid,
//   result_in                      ALU handshake and result
//   done                           one-cycle completion pulse
// All outputs are registered; they are decoded from the next state so they
// line up with the state they belong to.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [SEL_W-1:0] ra_sel,
  input  logic [SEL_W-1:0] rb_sel,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic [1:0]       num_src,
  input  logic             wb_en,
  output logic [SEL_W-1:0] register_select,
  output logic             reg_file_out,
  output logic             reg_file_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_out_en,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             exec_req,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result_in,
  output logic             done
);

  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(REG_ZERO);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [1:0]         nsrc_q, nsrc_d;
  logic               wb_q, wb_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;

  logic               ready_q, ready_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               rf_out_q, rf_out_d, rf_in_q, rf_in_d;
  logic               bus_out_en_q, bus_out_en_d;
  logic [WIDTH-1:0]   bus_out_q, bus_out_d;
  logic               exec_req_q, exec_req_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    nsrc_d   = nsrc_q;
    wb_d     = wb_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ra_d   = ra_sel;
          rb_d   = rb_sel;
          rd_d   = rd_sel;
          nsrc_d = eff_num_src(num_src);
          wb_d   = wb_en;
          // Operands that will not be read this request are zeroed now.
          if (nsrc_d == 2'd0) op_a_d = '0;
          if (nsrc_d != 2'd2) op_b_d = '0;
          state_d = (nsrc_d != 2'd0) ? ST_READ_A : ST_EXEC;
        end
      end
      ST_READ_A: begin
        // r0 is never driven onto the bus; its value is defined as zero.
        op_a_d  = (ra_q == SEL_ZERO) ? '0 : bus_in;
        state_d = (nsrc_q == 2'd2) ? ST_READ_B : ST_EXEC;
      end
      ST_READ_B: begin
        op_b_d  = (rb_q == SEL_ZERO) ? '0 : bus_in;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (result_valid) begin
          result_d = result_in;
          state_d  = wb_q ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Output decode from the upcoming state.
    ready_d      = (state_d == ST_IDLE);
    sel_d        = '0;
    rf_out_d     = 1'b0;
    rf_in_d      = 1'b0;
    bus_out_en_d = 1'b0;
    bus_out_d    = '0;
    exec_req_d   = (state_d == ST_EXEC);
    done_d       = (state_d == ST_DONE);
    case (state_d)
      ST_READ_A: begin
        sel_d    = ra_d;
        rf_out_d = (ra_d != SEL_ZERO);
      end
      ST_READ_B: begin
        sel_d    = rb_d;
        rf_out_d = (rb_d != SEL_ZERO);
      end
      ST_WRITE: begin
        sel_d        = rd_d;
        bus_out_en_d = 1'b1;
        bus_out_d    = result_d;
        rf_in_d      = (rd_d != SEL_ZERO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ra_q         <= '0;
      rb_q         <= '0;
      rd_q         <= '0;
      nsrc_q       <= '0;
      wb_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      ready_q      <= 1'b1;
      sel_q        <= '0;
      rf_out_q     <= 1'b0;
      rf_in_q      <= 1'b0;
      bus_out_en_q <= 1'b0;
      bus_out_q    <= '0;
      exec_req_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rd_q         <= rd_d;
      nsrc_q       <= nsrc_d;
      wb_q         <= wb_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      ready_q      <= ready_d;
      sel_q        <= sel_d;
      rf_out_q     <= rf_out_d;
      rf_in_q      <= rf_in_d;
      bus_out_en_q <= bus_out_en_d;
      bus_out_q    <= bus_out_d;
      exec_req_q   <= exec_req_d;
      done_q       <= done_d;
    end
  end

  assign ready           = ready_q;
  assign register_select = sel_q;
  assign reg_file_out    = rf_out_q;
  // The write strobe is masked by rst so a reset landing in WRITE never
  // commits the register-file write at that same edge.
  assign reg_file_in     = rf_in_q & ~rst;
  assign bus_out_en      = bus_out_en_q;
  assign bus_out         = bus_out_q;
  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign exec_req        = exec_req_q;
  assign done            = done_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
`timescale 1ns/1ps
module tb_regfile_sequencer;

  localparam int W = 16;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst, start, wb_en;
  logic [S-1:0]  ra_sel, rb_sel, rd_sel;
  logic [1:0]    num_src;
  logic          ready, reg_file_out, reg_file_in, bus_out_en, exec_req, done;
  logic [S-1:0]  register_select;
  logic [W-1:0]  bus_in, bus_out, op_a, op_b;
  logic          result_valid = 1'b0;
  logic [W-1:0]  result_in = '0;

  regfile_sequencer #(.WIDTH(W), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rd_sel(rd_sel),
    .num_src(num_src), .wb_en(wb_en),
    .register_select(register_select), .reg_file_out(reg_file_out),
    .reg_file_in(reg_file_in), .bus_in(bus_in), .bus_out(bus_out),
    .bus_out_en(bus_out_en), .op_a(op_a), .op_b(op_b),
    .exec_req(exec_req), .result_valid(result_valid),
    .result_in(result_in), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic timeout(input string what);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_event required=event_within_bound", what);
    finish_now();
  endtask

  // ---------------- register file stand-in (r0 stored, so a bad r0 write is visible)
  logic [W-1:0] regs [16];
  logic [W-1:0] init_vals [16];
  logic         load_regs;
  always @(posedge clk) begin
    if (load_regs) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_vals[i];
    end else if (reg_file_in) begin
      regs[register_select] <= bus_in;
    end
  end
  assign bus_in = reg_file_out ? regs[register_select] : (bus_out_en ? bus_out : '0);

  // ---------------- ALU stand-in: answers after alu_delay extra EXEC cycles
  int           alu_delay = 0;
  int           exec_cnt = 0;
  logic [W-1:0] alu_value = '0;
  always @(negedge clk) begin
    if (exec_req) begin
      result_valid <= (exec_cnt == alu_delay);
      result_in    <= (exec_cnt == alu_delay) ? alu_value : 16'hDEAD;
      exec_cnt     <= exec_cnt + 1;
    end else begin
      result_valid <= 1'b0;
      result_in    <= '0;
      exec_cnt     <= 0;
    end
  end

  // ---------------- reference model + scoreboard
  typedef struct {
    logic [W-1:0] op_a, op_b, rd_val;
    logic [S-1:0] rd;
    int accept, lat, rfo, rfi, boe, exe;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] model [16];

  int n_rfo = 0, n_rfi = 0, n_boe = 0, n_exe = 0, n_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_rfo = 0; n_rfi = 0; n_boe = 0; n_exe = 0; n_bad = 0;
    end else begin
      if (reg_file_out) n_rfo++;
      if (reg_file_in)  n_rfi++;
      if (bus_out_en)   n_boe++;
      if (exec_req)     n_exe++;
      if (reg_file_in && reg_file_out) n_bad++;
      if (bus_out_en && reg_file_out)  n_bad++;
      if (!(reg_file_out || reg_file_in || bus_out_en) && register_select != '0) n_bad++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=done_pulse required=no_pulse (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          $display("txn rd=%0d lat=%0d op_a=%h op_b=%h r[rd]=%h", e.rd, cyc - e.accept, op_a, op_b, regs[e.rd]);
          chk("latency", 32'(cyc - e.accept), 32'(e.lat));
          chk("op_a", 32'(op_a), 32'(e.op_a));
          chk("op_b", 32'(op_b), 32'(e.op_b));
          chk("reg_rd", 32'(regs[e.rd]), 32'(e.rd_val));
          chk("reg_r0", 32'(regs[0]), 32'h0);
          chk("rf_out_cycles", 32'(n_rfo), 32'(e.rfo));
          chk("rf_in_cycles", 32'(n_rfi), 32'(e.rfi));
          chk("bus_out_en_cycles", 32'(n_boe), 32'(e.boe));
          chk("exec_req_cycles", 32'(n_exe), 32'(e.exe));
          chk("strobe_rules", 32'(n_bad), 32'h0);
        end
        n_rfo = 0; n_rfi = 0; n_boe = 0; n_exe = 0; n_bad = 0;
      end
    end
  end

  // ---------------- driver
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready) begin
      tick();
      n++;
      if (n > 200) timeout("ready");
    end
  endtask

  task automatic issue(input logic [S-1:0] ra, input logic [S-1:0] rb, input logic [S-1:0] rd,
                       input logic [1:0] ns, input logic wb, input int dly, input logic [W-1:0] val);
    wait_ready();
    alu_delay = dly;
    alu_value = val;
    ra_sel = ra; rb_sel = rb; rd_sel = rd; num_src = ns; wb_en = wb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_txn(input logic [S-1:0] ra, input logic [S-1:0] rb, input logic [S-1:0] rd,
                         input logic [1:0] ns, input logic wb, input int dly,
                         input logic [W-1:0] val, input bit noise);
    exp_t e;
    int n;
    int k;
    n = (ns == 2'd3) ? 2 : int'(ns);
    e.op_a = (n >= 1 && ra != 0) ? model[ra] : '0;
    e.op_b = (n == 2 && rb != 0) ? model[rb] : '0;
    if (wb && rd != 0) model[rd] = val;
    e.rd     = rd;
    e.rd_val = model[rd];
    e.lat    = n + (dly + 1) + (wb ? 1 : 0) + 1;
    e.rfo    = ((n >= 1 && ra != 0) ? 1 : 0) + ((n == 2 && rb != 0) ? 1 : 0);
    e.rfi    = (wb && rd != 0) ? 1 : 0;
    e.boe    = wb ? 1 : 0;
    e.exe    = dly + 1;
    issue(ra, rb, rd, ns, wb, dly, val);
    e.accept = cyc - 1;
    sb.push_back(e);
    k = 0;
    while (!ready) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        ra_sel  = 4'($urandom); rb_sel = 4'($urandom); rd_sel = 4'($urandom);
        num_src = 2'($urandom); wb_en  = 1'($urandom);
      end
      tick();
      k++;
      if (k > 200) timeout("done");
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_regs = 1'b1;
    ra_sel = '0; rb_sel = '0; rd_sel = '0; num_src = '0; wb_en = 1'b0;
    for (int i = 0; i < 16; i++) init_vals[i] = 16'($urandom);
    init_vals[0] = 16'h0000;
    init_vals[1] = 16'h002A;
    init_vals[2] = 16'h0005;
    for (int i = 0; i < 16; i++) model[i] = init_vals[i];
    tick(); tick();
    load_regs = 1'b0;
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_exec_req", 32'(exec_req), 32'h0);
    chk("rst_op_a", 32'(op_a), 32'h0);
    chk("rst_op_b", 32'(op_b), 32'h0);
    chk("rst_strobes", {29'd0, reg_file_out, reg_file_in, bus_out_en}, 32'h0);
    chk("rst_select", 32'(register_select), 32'h0);

    // directed cases
    run_txn(4'd1, 4'd2, 4'd3, 2'd2, 1'b1, 0, 16'h002F, 1'b0);   // full op, done at +5
    run_txn(4'd0, 4'd9, 4'd4, 2'd1, 1'b1, 0, 16'h0007, 1'b0);   // r0 source
    run_txn(4'd1, 4'd2, 4'd0, 2'd2, 1'b1, 0, 16'hFFFF, 1'b0);   // write to r0 suppressed
    run_txn(4'd1, 4'd2, 4'd6, 2'd2, 1'b1, 4, 16'hBEEF, 1'b1);   // slow ALU + ignored starts, +9
    run_txn(4'd7, 4'd8, 4'd9, 2'd0, 1'b0, 0, 16'h5555, 1'b0);   // EXEC+DONE only, +2
    run_txn(4'd3, 4'd1, 4'd10, 2'd3, 1'b1, 1, 16'h1357, 1'b0);  // num_src=3 acts as 2

    // reset landing in WRITE: no write to r5, operands cleared
    begin
      int k = 0;
      issue(4'd1, 4'd2, 4'd5, 2'd2, 1'b1, 0, 16'h1234);
      while (!bus_out_en) begin
        tick();
        k++;
        if (k > 50) timeout("write");
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wrst_r5", 32'(regs[5]), 32'(model[5]));
      chk("wrst_ready", 32'(ready), 32'h1);
      chk("wrst_strobes", {28'd0, reg_file_out, reg_file_in, bus_out_en, exec_req}, 32'h0);
      chk("wrst_done", 32'(done), 32'h0);
      chk("wrst_ops", {op_a, op_b}, 32'h0);
    end

    // start coinciding with rst is dropped
    ra_sel = 4'd1; rb_sel = 4'd2; rd_sel = 4'd7; num_src = 2'd2; wb_en = 1'b1;
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_ready", 32'(ready), 32'h1);
    chk("rst_start_exec", 32'(exec_req), 32'h0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    for (int i = 0; i < 16; i++) chk("final_reg", 32'(regs[i]), 32'(model[i]));
    finish_now();
  end

endmodule
